// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the EX-stage branch controller.
// Holds XLEN and its machine-word type, the controller state type and the B-type condition codes.
package branch_ctrl_pkg;
   localparam int XLEN = 64;
   typedef logic [XLEN-1:0] uintx_t;

   typedef enum logic {BC_IDLE, BC_WAIT} br_state_t;

   localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
   localparam logic [2:0] FUNCT3_BNE  = 3'b001;
   localparam logic [2:0] FUNCT3_BLT  = 3'b100;
   localparam logic [2:0] FUNCT3_BGE  = 3'b101;
   localparam logic [2:0] FUNCT3_BLTU = 3'b110;
   localparam logic [2:0] FUNCT3_BGEU = 3'b111;
endpackage

// File: rtl/branch_ctrl_if.sv
// EX-instruction bundle plus the redirect handshake toward fetch.
interface branch_ctrl_if;
   import branch_ctrl_pkg::*;

   logic       ex_valid;
   logic       ex_is_br;
   logic       ex_is_jal;
   logic       ex_is_jalr;
   logic [2:0] ex_funct3;
   uintx_t     ex_pc;
   uintx_t     ex_op1;
   uintx_t     ex_op2;
   uintx_t     ex_imm;

   // A redirect transfers on every cycle where redirect_valid && redirect_ready.
   // Once raised, redirect_valid and redirect_pc stay stable until that transfer.
   logic       redirect_valid;
   logic       redirect_ready;
   uintx_t     redirect_pc;

   modport master (
      output ex_valid, ex_is_br, ex_is_jal, ex_is_jalr, ex_funct3,
             ex_pc, ex_op1, ex_op2, ex_imm, redirect_ready,
      input  redirect_valid, redirect_pc
   );

   modport slave (
      input  ex_valid, ex_is_br, ex_is_jal, ex_is_jalr, ex_funct3,
             ex_pc, ex_op1, ex_op2, ex_imm, redirect_ready,
      output redirect_valid, redirect_pc
   );
endinterface

// File: rtl/branch_ctrl_brunit.sv
// Conditional-branch comparator: decides whether a B-type instruction is taken.
module branch_ctrl_brunit
   import branch_ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  uintx_t     op1,
   input  uintx_t     op2,
   output logic       take
);
   always_comb begin
      take = 1'b0;
      case (funct3)
         FUNCT3_BEQ:  take = (op1 == op2);
         FUNCT3_BNE:  take = (op1 != op2);
         FUNCT3_BLT:  take = ($signed(op1) <  $signed(op2));
         FUNCT3_BGE:  take = ($signed(op1) >= $signed(op2));
         FUNCT3_BLTU: take = (op1 <  op2);
         FUNCT3_BGEU: take = (op1 >= op2);
         default:     take = 1'b0;
      endcase
   end
endmodule

// File: rtl/branch_ctrl.sv
// EX-stage control-transfer sequencer: evaluates branches/jumps, issues a registered
// redirect to fetch, flushes IF/ID, stalls EX until accepted, and flags misaligned targets.
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int IALIGN = 32,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   branch_ctrl_if.slave     bus,
   input  logic             trap_flush,
   output logic             flush_front,
   output logic             ex_stall,
   output logic             exc_misalign,
   output uintx_t           exc_tval,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] br_taken_count,
   output br_state_t        dbg_state
);
   br_state_t        state_q, state_d;
   logic             rv_q, rv_d;
   uintx_t           rpc_q, rpc_d;
   logic             flush_q, flush_d;
   logic             exc_q, exc_d;
   uintx_t           tval_q, tval_d;
   logic [CNT_W-1:0] brc_q, brc_d;
   logic [CNT_W-1:0] tkc_q, tkc_d;

   logic   take;
   logic   xfer;
   logic   misaligned;
   uintx_t target;

   branch_ctrl_brunit u_brunit (
      .funct3 (bus.ex_funct3),
      .op1    (bus.ex_op1),
      .op2    (bus.ex_op2),
      .take   (take)
   );

   always_comb begin
      if (bus.ex_is_jalr) target = (bus.ex_op1 + bus.ex_imm) & ~uintx_t'(1);
      else                target = bus.ex_pc + bus.ex_imm;
      // With 16-bit alignment bit 0 is ignored, so no target can be misaligned.
      misaligned = (IALIGN == 32) ? (target[1:0] != 2'b00) : 1'b0;
      xfer = bus.ex_valid & ((bus.ex_is_br & take) | bus.ex_is_jal | bus.ex_is_jalr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BC_IDLE;
         rv_q    <= 1'b0;
         rpc_q   <= '0;
         flush_q <= 1'b0;
         exc_q   <= 1'b0;
         tval_q  <= '0;
         brc_q   <= '0;
         tkc_q   <= '0;
      end else begin
         state_q <= state_d;
         rv_q    <= rv_d;
         rpc_q   <= rpc_d;
         flush_q <= flush_d;
         exc_q   <= exc_d;
         tval_q  <= tval_d;
         brc_q   <= brc_d;
         tkc_q   <= tkc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BC_IDLE: if (!trap_flush && xfer && !misaligned) state_d = BC_WAIT;
         BC_WAIT: if (trap_flush || (rv_q && bus.redirect_ready)) state_d = BC_IDLE;
         default: state_d = BC_IDLE;
      endcase
   end

   // Datapath registers; trap_flush suppresses evaluation and counting entirely.
   always_comb begin
      rv_d    = rv_q;
      rpc_d   = rpc_q;
      flush_d = 1'b0;
      exc_d   = 1'b0;
      tval_d  = tval_q;
      brc_d   = brc_q;
      tkc_d   = tkc_q;
      if (trap_flush) begin
         rv_d = 1'b0;
      end else if (state_q == BC_WAIT) begin
         if (rv_q && bus.redirect_ready) rv_d = 1'b0;
      end else begin
         if (bus.ex_valid && bus.ex_is_br) begin
            brc_d = brc_q + CNT_W'(1);
            if (take) tkc_d = tkc_q + CNT_W'(1);
         end
         if (xfer && misaligned) begin
            exc_d  = 1'b1;
            tval_d = target;
         end else if (xfer) begin
            rv_d    = 1'b1;
            rpc_d   = target;
            flush_d = 1'b1;
         end
      end
   end

   always_comb begin
      ex_stall           = (state_q == BC_WAIT);
      dbg_state          = state_q;
      bus.redirect_valid = rv_q;
      bus.redirect_pc    = rpc_q;
      flush_front        = flush_q;
      exc_misalign       = exc_q;
      exc_tval           = tval_q;
      br_count           = brc_q;
      br_taken_count     = tkc_q;
   end
endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: IALIGN=32 and IALIGN=16 instances share stimulus and are checked
// every cycle against a transaction-level reference model.
module tb_branch_ctrl;
   import branch_ctrl_pkg::*;

   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        ex_valid = 1'b0, ex_is_br = 1'b0, ex_is_jal = 1'b0, ex_is_jalr = 1'b0;
   logic [2:0]  ex_funct3 = 3'd0;
   logic [63:0] ex_pc = '0, ex_op1 = '0, ex_op2 = '0, ex_imm = '0;
   logic        trap_flush = 1'b0, ready = 1'b0;

   branch_ctrl_if bus_a ();
   branch_ctrl_if bus_b ();

   assign bus_a.ex_valid = ex_valid;     assign bus_b.ex_valid = ex_valid;
   assign bus_a.ex_is_br = ex_is_br;     assign bus_b.ex_is_br = ex_is_br;
   assign bus_a.ex_is_jal = ex_is_jal;   assign bus_b.ex_is_jal = ex_is_jal;
   assign bus_a.ex_is_jalr = ex_is_jalr; assign bus_b.ex_is_jalr = ex_is_jalr;
   assign bus_a.ex_funct3 = ex_funct3;   assign bus_b.ex_funct3 = ex_funct3;
   assign bus_a.ex_pc = ex_pc;           assign bus_b.ex_pc = ex_pc;
   assign bus_a.ex_op1 = ex_op1;         assign bus_b.ex_op1 = ex_op1;
   assign bus_a.ex_op2 = ex_op2;         assign bus_b.ex_op2 = ex_op2;
   assign bus_a.ex_imm = ex_imm;         assign bus_b.ex_imm = ex_imm;
   assign bus_a.redirect_ready = ready;  assign bus_b.redirect_ready = ready;

   logic        flush_a, stall_a, exc_a, flush_b, stall_b, exc_b;
   logic [63:0] tval_a, tval_b;
   logic [CW-1:0] brc_a, tkc_a, brc_b, tkc_b;
   br_state_t   st_a, st_b;

   branch_ctrl #(.IALIGN(32), .CNT_W(CW)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a), .trap_flush(trap_flush),
      .flush_front(flush_a), .ex_stall(stall_a), .exc_misalign(exc_a), .exc_tval(tval_a),
      .br_count(brc_a), .br_taken_count(tkc_a), .dbg_state(st_a)
   );

   branch_ctrl #(.IALIGN(16), .CNT_W(CW)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b), .trap_flush(trap_flush),
      .flush_front(flush_b), .ex_stall(stall_b), .exc_misalign(exc_b), .exc_tval(tval_b),
      .br_count(brc_b), .br_taken_count(tkc_b), .dbg_state(st_b)
   );

   int checks = 0;
   int failures = 0;

   // Reference model, index 0 = IALIGN 32, index 1 = IALIGN 16.
   logic          m_rv[2], m_flush[2], m_exc[2];
   logic [63:0]   m_rpc[2], m_tval[2];
   logic [CW-1:0] m_brc[2], m_tkc[2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic ref_take(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_rv[i] = 0; m_flush[i] = 0; m_exc[i] = 0;
         m_rpc[i] = '0; m_tval[i] = '0; m_brc[i] = '0; m_tkc[i] = '0;
      end
   endtask

   task automatic model_step();
      logic tk, xf;
      logic [63:0] tgt;
      tk  = ref_take(ex_funct3, ex_op1, ex_op2);
      tgt = ex_is_jalr ? ((ex_op1 + ex_imm) & ~64'd1) : (ex_pc + ex_imm);
      xf  = ex_valid && ((ex_is_br && tk) || ex_is_jal || ex_is_jalr);
      for (int i = 0; i < 2; i++) begin
         m_flush[i] = 0;
         m_exc[i]   = 0;
         if (trap_flush) m_rv[i] = 0;
         else if (m_rv[i]) begin
            if (ready) m_rv[i] = 0;
         end else begin
            if (ex_valid && ex_is_br) begin
               m_brc[i] = m_brc[i] + 1;
               if (tk) m_tkc[i] = m_tkc[i] + 1;
            end
            if (xf) begin
               if (i == 0 && tgt[1:0] != 2'b00) begin
                  m_exc[i] = 1; m_tval[i] = tgt;
               end else begin
                  m_rv[i] = 1; m_rpc[i] = tgt; m_flush[i] = 1;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      chk("a_rvalid", 64'(bus_a.redirect_valid), 64'(m_rv[0]));
      chk("a_rpc",    bus_a.redirect_pc,         m_rpc[0]);
      chk("a_flush",  64'(flush_a),              64'(m_flush[0]));
      chk("a_stall",  64'(stall_a),              64'(m_rv[0]));
      chk("a_exc",    64'(exc_a),                64'(m_exc[0]));
      chk("a_tval",   tval_a,                    m_tval[0]);
      chk("a_brc",    64'(brc_a),                64'(m_brc[0]));
      chk("a_tkc",    64'(tkc_a),                64'(m_tkc[0]));
      chk("b_rvalid", 64'(bus_b.redirect_valid), 64'(m_rv[1]));
      chk("b_rpc",    bus_b.redirect_pc,         m_rpc[1]);
      chk("b_flush",  64'(flush_b),              64'(m_flush[1]));
      chk("b_stall",  64'(stall_b),              64'(m_rv[1]));
      chk("b_exc",    64'(exc_b),                64'(m_exc[1]));
      chk("b_tval",   tval_b,                    m_tval[1]);
      chk("b_brc",    64'(brc_b),                64'(m_brc[1]));
      chk("b_tkc",    64'(tkc_b),                64'(m_tkc[1]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                        input logic [2:0] f3, input logic [63:0] pc, input logic [63:0] op1,
                        input logic [63:0] op2, input logic [63:0] imm,
                        input logic trap, input logic rdy);
      ex_valid = v; ex_is_br = br; ex_is_jal = jal; ex_is_jalr = jalr; ex_funct3 = f3;
      ex_pc = pc; ex_op1 = op1; ex_op2 = op2; ex_imm = imm; trap_flush = trap; ready = rdy;
   endtask

   task automatic idle(input logic rdy);
      drive(0, 0, 0, 0, 3'd0, '0, '0, '0, '0, 0, rdy);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] b8;
      int kind;
      model_reset();
      do_reset();

      // BEQ equal operands: redirect to 0x120 with flush, then accepted
      drive(1, 1, 0, 0, 3'd0, 64'h100, 64'd5, 64'd5, 64'h20, 0, 1);
      tick();
      chk("beq_pc", bus_a.redirect_pc, 64'h120);
      chk("beq_flush", 64'(flush_a), 64'd1);
      idle(1); tick();
      chk("beq_idle", 64'(bus_a.redirect_valid), 64'd0);
      chk("beq_cnt", 64'(brc_a), 64'd1);

      // BLTU taken vs BLT not taken on the same operands
      drive(1, 1, 0, 0, 3'd6, 64'h300, 64'd1, '1, 64'h10, 0, 1);
      tick();
      chk("bltu_taken", 64'(bus_a.redirect_valid), 64'd1);
      idle(1); tick();
      drive(1, 1, 0, 0, 3'd4, 64'h300, 64'd1, '1, 64'h10, 0, 1);
      tick();
      chk("blt_nottaken", 64'(bus_a.redirect_valid), 64'd0);
      chk("blt_taken_cnt", 64'(tkc_a), 64'd2);

      // JALR to 0x1002: redirect with IALIGN 16, misalign trap with IALIGN 32
      drive(1, 0, 0, 1, 3'd0, 64'h400, 64'h1003, '0, '0, 0, 1);
      tick();
      chk("jalr16_pc", bus_b.redirect_pc, 64'h1002);
      chk("jalr32_exc", 64'(exc_a), 64'd1);
      chk("jalr32_tval", tval_a, 64'h1002);
      idle(1); tick();

      // JAL with fetch back-pressure for three cycles; EX junk is ignored while waiting
      drive(1, 0, 1, 0, 3'd0, 64'h200, '0, '0, 64'h40, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 0, 3'd0, 64'h800, '0, '0, 64'h8, 0, 0);
         tick();
         chk("jal_hold_pc", bus_a.redirect_pc, 64'h240);
      end
      idle(1); tick();
      idle(1); tick();

      // trap_flush in WAIT, then trap_flush with a concurrent taken BNE
      drive(1, 0, 1, 0, 3'd0, 64'h500, '0, '0, 64'h4, 0, 0);
      tick();
      drive(0, 0, 0, 0, 3'd0, '0, '0, '0, '0, 1, 0);
      tick();
      drive(1, 1, 0, 0, 3'd1, 64'h600, 64'd1, 64'd2, 64'h8, 1, 1);
      tick();
      chk("trap_bne_rv", 64'(bus_a.redirect_valid), 64'd0);

      // Asynchronous reset mid-WAIT
      drive(1, 0, 1, 0, 3'd0, 64'h700, '0, '0, 64'h4, 0, 0);
      tick();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("rst_async_rv", 64'(bus_a.redirect_valid), 64'd0);
      #1 rst = 1'b0;

      // Counter wrap: 16 not-taken branches from zero
      for (int i = 0; i < 16; i++) begin
         drive(1, 1, 0, 0, 3'd1, 64'h100, 64'd9, 64'd9, 64'h8, 0, 1);
         tick();
         if (i == 14) chk("wrap_max", 64'(brc_a), 64'hF);
      end
      chk("wrap_zero", 64'(brc_a), 64'd0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 3);
         b8 = 8'($urandom_range(0, 255));
         ex_valid   = ($urandom_range(0, 7) != 0);
         ex_is_br   = (kind == 0);
         ex_is_jal  = (kind == 1);
         ex_is_jalr = (kind == 2);
         ex_funct3  = 3'($urandom_range(0, 7));
         ex_pc      = {32'h0, $urandom} & ~64'h1;
         ex_imm     = {{56{b8[7]}}, b8};
         ex_op1     = {$urandom, $urandom};
         ex_op2     = ($urandom_range(0, 3) == 0) ? ex_op1 : {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) ex_op2 = ex_op2 ^ 64'h8000_0000_0000_0000;
         trap_flush = ($urandom_range(0, 19) == 0);
         ready      = ($urandom_range(0, 1) == 1);
         tick();
      end

      idle(1); tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
